// File: rtl/sram_seq_pkg.sv
// sram_seq_pkg: shared state encoding and request entry layout for the SRAM request sequencer
package sram_seq_pkg;
  localparam int CMD_DW = 8;
  localparam int CMD_AW = 15;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef struct packed {
    logic              we;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } req_t;
endpackage

// File: rtl/sram_req_fifo.sv
// sram_req_fifo: synchronous FIFO with count-derived full/empty and naturally wrapping pointers
module sram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/sram_req_sequencer.sv
// sram_req_sequencer: queues client requests and issues them one at a time to the SRAM controller
module sram_req_sequencer
  import sram_seq_pkg::*;
#(
  parameter int DW = CMD_DW,
  parameter int AW = CMD_AW,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DW-1:0]          rsp_rdata,
  output logic                   ctl_enable,
  output logic                   ctl_readenable,
  output logic                   ctl_writeenable,
  output logic [AW-1:0]          ctl_addr,
  output logic [DW-1:0]          ctl_wdata,
  input  logic [DW-1:0]          ctl_rdata,
  input  logic                   ctl_rd_done,
  input  logic                   ctl_wr_done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout_err
);
  localparam int TW = $clog2(TIMEOUT);
  state_t state, state_nx;
  req_t head, req_in;
  logic empty, full, pop, cmd_we, done, tmo_hit;
  logic [TW-1:0] tmo;
  assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata};
  sram_req_fifo #(.DEPTH(DEPTH), .W($bits(req_t))) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(req_valid), .pop(pop), .din(req_in), .dout(head),
    .full(full), .empty(empty), .count(fifo_count)
  );
  assign req_ready = !full;
  assign done = cmd_we ? ctl_wr_done : ctl_rd_done;
  assign tmo_hit = tmo == TW'(TIMEOUT - 1);
  assign ctl_enable = state == ISSUE;
  assign ctl_writeenable = ctl_enable && cmd_we;
  assign ctl_readenable = ctl_enable && !cmd_we;
  // a pending response blocks reads only; writes may still drain past it
  always_comb begin
    pop = state == IDLE && !empty && (head.we || !rsp_valid);
    state_nx = pop ? ISSUE :
               state == ISSUE ? WAIT :
               (state == WAIT && (done || tmo_hit)) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_we <= 1'b0;
      ctl_addr <= '0;
      ctl_wdata <= '0;
      tmo <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        cmd_we <= head.we;
        ctl_addr <= head.addr;
        ctl_wdata <= head.wdata;
      end
      tmo <= state == WAIT ? tmo + 1'b1 : '0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (state == WAIT && done && !cmd_we) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= ctl_rdata;
      end
      if (state == WAIT && !done && tmo_hit) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_req_sequencer.sv
// tb_sram_req_sequencer: directed and randomized checks against a queue-and-memory reference model
module tb_sram_req_sequencer;
  localparam int DW = 8, AW = 15, DEPTH = 4, TIMEOUT = 16;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, ctl_rdata = '0;
  logic ctl_rd_done = 0, ctl_wr_done = 0;
  logic req_ready, rsp_valid, ctl_enable, ctl_readenable, ctl_writeenable, timeout_err;
  logic [DW-1:0] rsp_rdata, ctl_wdata;
  logic [AW-1:0] ctl_addr;
  logic [$clog2(DEPTH):0] fifo_count;
  int errors = 0, checks = 0;

  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_s;
  req_s exp_q[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] sram [32];
  logic busy = 0, prev_en = 0, exp_terr = 0, cur_we = 0;
  logic [4:0] cur_a = '0;
  logic [DW-1:0] cur_d = '0;
  int cnt = 0, cyc = 0, tmo_at = -1, strobes = 0;
  int fixed_lat = 0, stall_strobe = -1;

  sram_req_sequencer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .ctl_enable(ctl_enable), .ctl_readenable(ctl_readenable),
    .ctl_writeenable(ctl_writeenable), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_rdata(ctl_rdata), .ctl_rd_done(ctl_rd_done), .ctl_wr_done(ctl_wr_done),
    .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Controller/SRAM model plus scoreboard, sampled mid-cycle away from the DUT clock edge
  always @(negedge clk) begin
    req_s e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      rsp_q.delete();
      busy = 0; prev_en = 0; exp_terr = 0; tmo_at = -1;
      ctl_rd_done = 0; ctl_wr_done = 0;
      for (int i = 0; i < 32; i++) sram[i] = DW'($urandom);
    end else begin
      ctl_rd_done = 0;
      ctl_wr_done = 0;
      ctl_rdata = DW'($urandom);
      if (busy) begin
        if (cnt == 1) begin
          busy = 0;
          if (cur_we) begin sram[cur_a] = cur_d; ctl_wr_done = 1; end
          else begin ctl_rdata = sram[cur_a]; ctl_rd_done = 1; end
        end else begin
          cnt--;
          if (cur_we) ctl_rd_done = ($urandom % 4) == 0;
          else ctl_wr_done = ($urandom % 4) == 0;
        end
      end
      if (cyc == tmo_at) exp_terr = 1;
      chk("timeout_err", timeout_err, exp_terr);
      chk("stray_strobe", (ctl_readenable | ctl_writeenable) & ~ctl_enable, 0);
      if (ctl_enable) begin
        strobes++;
        chk("back_to_back", prev_en, 0);
        chk("overlap", busy, 0);
        if (exp_q.size() == 0) chk("extra_strobe", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("strobe_type", {ctl_writeenable, ctl_readenable}, e.we ? 2'b10 : 2'b01);
          chk("ctl_addr", ctl_addr, e.addr);
          chk("ctl_wdata", ctl_wdata, e.wdata);
          if (!e.we) chk("read_while_rsp", rsp_valid, 0);
          if (strobes == stall_strobe) tmo_at = cyc + TIMEOUT + 1;
          else begin
            busy = 1;
            cnt = fixed_lat != 0 ? fixed_lat : $urandom_range(1, 6);
            cur_we = ctl_writeenable;
            cur_a = ctl_addr[4:0];
            cur_d = ctl_wdata;
            if (!e.we) rsp_q.push_back(sram[e.addr[4:0]]);
          end
        end
      end
      prev_en = ctl_enable;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("rsp_extra", 1, 0);
        else begin
          chk("rsp_rdata", rsp_rdata, rsp_q[0]);
          if (rsp_ready) void'(rsp_q.pop_front());
        end
      end
      chk("fifo_count", fifo_count, exp_q.size());
      chk("req_ready", req_ready, exp_q.size() < DEPTH);
      if (req_valid && req_ready) exp_q.push_back(req_s'{req_we, req_addr, req_wdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic we, input int a, input int d);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = AW'(a); req_wdata = DW'(d);
    while (!req_ready && n < 500) begin step(); n++; end
    chk("push_accept", n < 500, 1);
    step();
    req_valid = 0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 100) begin step(); n++; end
    chk("rsp_arrive", rsp_valid, 1);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0 || busy || ctl_enable) && n < 2000) begin
      step(); n++;
    end
    chk("quiet", n < 2000, 1);
    repeat (2) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    repeat (2) step();
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_strobes", {ctl_enable, ctl_readenable, ctl_writeenable}, 0);
    chk("rst_ctl_addr", ctl_addr, 0);
    chk("rst_ctl_wdata", ctl_wdata, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    chk("rst_terr", timeout_err, 0);
    rst_n = 1;
    step();
    // write 0xAA to 0x00A with a fixed 4-cycle controller latency
    fixed_lat = 4;
    s0 = strobes;
    push(1, 'h00A, 'hAA);
    wait_quiet();
    chk("wr_pulses", strobes - s0, 1);
    chk("wr_no_rsp", rsp_valid, 0);
    // read it back and hold the response
    push(0, 'h00A, 0);
    wait_rsp();
    chk("rd_rdata", rsp_rdata, 'hAA);
    repeat (3) step();
    chk("rsp_hold", rsp_valid, 1);
    chk("rsp_hold_data", rsp_rdata, 'hAA);
    rsp_ready = 1;
    step();
    chk("rsp_clear", rsp_valid, 0);
    rsp_ready = 0;
    // second read blocked by unaccepted response, then fill the FIFO
    fixed_lat = 0;
    push(0, 1, 0);
    push(0, 2, 0);
    wait_rsp();
    repeat (8) step();
    chk("rd_blocked_cnt", fifo_count, 1);
    push(0, 3, 0);
    push(0, 4, 0);
    push(0, 5, 0);
    chk("fill_cnt", fifo_count, 4);
    chk("fill_ready", req_ready, 0);
    fork
      push(0, 6, 0);
      begin repeat (6) step(); rsp_ready = 1; end
    join
    wait_quiet();
    // stalled write times out; the following read still issues
    stall_strobe = strobes + 1;
    push(1, 3, 'h55);
    push(0, 3, 0);
    wait_quiet();
    chk("timeout_sticky", timeout_err, 1);
    // reset while waiting with three requests queued
    stall_strobe = strobes + 1;
    push(1, 7, 1);
    push(1, 8, 2);
    push(1, 9, 3);
    push(1, 10, 4);
    repeat (2) step();
    chk("pre_rst_cnt", fifo_count, 3);
    rst_n = 0;
    step();
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_strobes", {ctl_enable, ctl_readenable, ctl_writeenable}, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_ready", req_ready, 1);
    rst_n = 1;
    step();
    // randomized traffic with random response back-pressure
    for (int i = 0; i < 800; i++) begin
      logic acc;
      acc = req_valid && req_ready;
      step();
      if (acc || !req_valid) begin
        req_valid = ($urandom % 3) == 0;
        req_we = 1'($urandom);
        req_addr = AW'($urandom % 32);
        req_wdata = DW'($urandom);
      end
      rsp_ready = 1'($urandom);
    end
    req_valid = 0;
    rsp_ready = 1;
    wait_quiet();
    chk("end_terr", timeout_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
